// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and default timing constants for the button conditioner
package button_pkg;
    localparam int CLK30_HZ = 30_000_000;
    localparam int DEBOUNCE_DEF = 300_000;
    localparam int HOLD_DEF = 15_000_000;
    localparam int REPEAT_DEF = 3_000_000;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRESS_DB = 3'd1;
    localparam logic [2:0] S_PRESSED = 3'd2;
    localparam logic [2:0] S_HELD = 3'd3;
    localparam logic [2:0] S_RELEASE_DB = 3'd4;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: one channel of sync, debounce, edge detect and hold/auto-repeat
// Ports: clk30 clock; rst async active-high; button raw active-low pin;
//        btn_level debounced pressed; btn_press/btn_release one-cycle pulses;
//        btn_hold high while held; btn_repeat pulse on hold entry and each repeat period
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int HOLD_CYCLES = HOLD_DEF,
    parameter int REPEAT_CYCLES = REPEAT_DEF
) (
    input  logic clk30,
    input  logic rst,
    input  logic button,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold,
    output logic btn_repeat
);
    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] R_LAST = CW'(REPEAT_CYCLES - 1);
    logic sync1, sync2, p, wrap, wrap_d;
    logic [2:0] state, prev, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic level_d, press_d, release_d, hold_d, repeat_d;
    assign p = ~sync2;
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            prev <= S_IDLE;
            cnt <= '0;
            wrap <= 1'b0;
        end else begin
            state <= nxt;
            prev <= state;
            cnt <= cnt_nxt;
            wrap <= wrap_d;
        end
    end
    // cnt_nxt defaults to zero so every state change clears the counter
    always_comb begin
        nxt = S_IDLE;
        cnt_nxt = '0;
        wrap_d = 1'b0;
        case (state)
            S_IDLE: nxt = p ? S_PRESS_DB : S_IDLE;
            S_PRESS_DB: begin
                nxt = !p ? S_IDLE : (cnt == D_LAST) ? S_PRESSED : S_PRESS_DB;
                cnt_nxt = (nxt == S_PRESS_DB) ? cnt + 1'b1 : '0;
            end
            S_PRESSED: begin
                nxt = !p ? S_RELEASE_DB : (cnt == H_LAST) ? S_HELD : S_PRESSED;
                cnt_nxt = (nxt == S_PRESSED) ? cnt + 1'b1 : '0;
            end
            S_HELD: begin
                nxt = p ? S_HELD : S_RELEASE_DB;
                wrap_d = p && (cnt == R_LAST);
                cnt_nxt = (p && !wrap_d) ? cnt + 1'b1 : '0;
            end
            S_RELEASE_DB: begin
                nxt = p ? S_PRESSED : (cnt == D_LAST) ? S_IDLE : S_RELEASE_DB;
                cnt_nxt = (nxt == S_RELEASE_DB) ? cnt + 1'b1 : '0;
            end
            default: nxt = S_IDLE;
        endcase
    end
    // pulses decode the transition just taken, giving the documented D+3 latency
    always_comb begin
        level_d = (state == S_PRESSED) || (state == S_HELD) || (state == S_RELEASE_DB);
        hold_d = state == S_HELD;
        press_d = (prev == S_PRESS_DB) && (state == S_PRESSED);
        release_d = (prev == S_RELEASE_DB) && (state == S_IDLE);
        repeat_d = ((prev == S_PRESSED) && (state == S_HELD)) || wrap;
    end
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            btn_level <= 1'b0;
            btn_press <= 1'b0;
            btn_release <= 1'b0;
            btn_hold <= 1'b0;
            btn_repeat <= 1'b0;
        end else begin
            btn_level <= level_d;
            btn_press <= press_d;
            btn_release <= release_d;
            btn_hold <= hold_d;
            btn_repeat <= repeat_d;
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced level, press/release pulses and hold/repeat for NUM_BUTTONS active-low buttons
// Ports: clk30 clock; rst async active-high; button raw active-low pins;
//        btn_level/btn_press/btn_release/btn_hold/btn_repeat per-channel outputs
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int HOLD_CYCLES = HOLD_DEF,
    parameter int REPEAT_CYCLES = REPEAT_DEF
) (
    input  logic clk30,
    input  logic rst,
    input  logic [NUM_BUTTONS-1:0] button,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_hold,
    output logic [NUM_BUTTONS-1:0] btn_repeat
);
    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk30(clk30),
            .rst(rst),
            .button(button[g]),
            .btn_level(btn_level[g]),
            .btn_press(btn_press[g]),
            .btn_release(btn_release[g]),
            .btn_hold(btn_hold[g]),
            .btn_repeat(btn_repeat[g])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench checking debounce, pulses, hold/repeat and reset timing
module tb_button_conditioner;
    logic clk30 = 1'b0;
    logic rst;
    logic [1:0] button;
    logic [1:0] btn_level, btn_press, btn_release, btn_hold, btn_repeat;
    logic [9:0] exp_q[$];
    string tag_q[$];
    int n_checks = 0;
    int n_pass = 0;
    button_conditioner #(
        .NUM_BUTTONS(2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk30(clk30),
        .rst(rst),
        .button(button),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_hold(btn_hold),
        .btn_repeat(btn_repeat)
    );
    always #5 clk30 = ~clk30;
    function automatic logic [4:0] tl(input int k, input int n);
        logic lv, pr, rl, hd, rp;
        lv = (k >= 7) && (k < n + 7);
        pr = k == 7;
        rl = k == n + 7;
        hd = (n >= 15) && (k >= 17) && (k < n + 3);
        rp = hd && ((k - 17) % 3 == 0);
        return {lv, pr, rl, hd, rp};
    endfunction
    function automatic logic [9:0] pack(input logic [4:0] c1, input logic [4:0] c0);
        return {c1[4], c0[4], c1[3], c0[3], c1[2], c0[2], c1[1], c0[1], c1[0], c0[0]};
    endfunction
    task automatic push(input logic [9:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask
    task automatic push_tl(input logic [1:0] mask, input int n, input int kmax, input string t);
        for (int k = 0; k <= kmax; k++)
            push(pack(mask[1] ? tl(k, n) : 5'b0, mask[0] ? tl(k, n) : 5'b0), $sformatf("%s k=%0d", t, k));
    endtask
    task automatic check();
        logic [9:0] e, o;
        string t;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_underflow got empty want entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {btn_level, btn_press, btn_release, btn_hold, btn_repeat};
        assert (o === e) n_pass++;
        else $error("FAIL %s got %b want %b (lvl,prs,rel,hld,rpt x ch1,ch0)", t, o, e);
    endtask
    task automatic run(input logic [1:0] mask, input int n, input int n2, input int kmax);
        for (int k = 0; k <= kmax; k++) begin
            button = ((k < n) || (n2 >= 0 && k >= n2)) ? ~mask : 2'b11;
            @(negedge clk30);
            check();
        end
    endtask
    task automatic do_reset(input string t);
        button = 2'b11;
        rst = 1'b1;
        push('0, {t, " async"});
        #1 check();
        @(negedge clk30);
        push('0, {t, " held"});
        check();
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        button = 2'b10;
        push('0, "t1 in_reset a");
        push('0, "t1 in_reset b");
        @(negedge clk30);
        check();
        @(negedge clk30);
        check();
        rst = 1'b0;
        push_tl(2'b01, 1000, 9, "t1 press_after_reset");
        run(2'b01, 1000, -1, 9);
        do_reset("t1 reset");
        for (int k = 0; k <= 12; k++) push('0, $sformatf("t2 bounce k=%0d", k));
        run(2'b01, 3, -1, 12);
        for (int k = 0; k <= 20; k++)
            push(pack(5'b0, {k >= 7, k == 7, 3'b000}), $sformatf("t2 glitch k=%0d", k));
        run(2'b01, 10, 12, 20);
        do_reset("t2 reset");
        push_tl(2'b01, 40, 49, "t3 hold_release");
        run(2'b01, 40, -1, 49);
        push_tl(2'b11, 9, 18, "t5 simultaneous");
        run(2'b11, 9, -1, 18);
        push_tl(2'b01, 1000, 20, "t6 to_held");
        run(2'b01, 1000, -1, 20);
        #2 do_reset("t6 reset_in_held");
        for (int k = 0; k <= 10; k++) push('0, $sformatf("t6 after_reset k=%0d", k));
        run(2'b00, 0, -1, 10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
